assoc_cache_ctrl: RTL and testbench
===================================

Name: assoc_cache_ctrl

Overview:
Parametrised 2-way set-associative, write-through, no-write-allocate cache between the pipeline MEM stage and the SRAM controller. It serves read hits in the same cycle and fetches read misses from the backing memory port with a request/ready handshake. It keeps one LRU bit per set and stalls the pipeline through `ready`. The successor generalises the set count, tag width and data width, and adds reset-time invalidation, write-hit update with write-through and explicit victim selection.

Parameters:
DATA_W, 32, word width of pipeline and memory data
INDEX_W, 6, set index bits; sets = 2**INDEX_W
TAG_W, 10, tag bits taken above the index
ADDR_W, 32, pipeline address width; bits [1:0] are a byte offset and are ignored

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
address  in  ADDR_W  byte address from MEM stage
wdata  in  DATA_W  store data
MEM_R_EN  in  1  load request
MEM_W_EN  in  1  store request
rdata  out  DATA_W  load data, valid when ready=1 and MEM_R_EN=1
ready  out  1  high when the current request completes this cycle; low means stall
mem_rd_en  out  1  backing read request
mem_wr_en  out  1  backing write request
mem_addr  out  ADDR_W  backing address (equals address)
mem_wdata  out  DATA_W  backing write data (equals wdata)
mem_rdata  in  DATA_W  backing read data, valid when mem_ready=1
mem_ready  in  1  one-cycle completion pulse from backing memory

Behaviour:
- Address split:
  - index = address[INDEX_W+1:2]
  - tag = address[TAG_W+INDEX_W+1:INDEX_W+2]
  - higher bits ignored.
- Per set: valid0, tag0, data0, valid1, tag1, data1, lru. lru=0 means way0 is least recently used; lru=1 means way1 is.
- Reset (async): all valid bits cleared, all lru bits=0, FSM=IDLE, mem_rd_en=0, mem_wr_en=0, ready=1, rdata=0. Tag/data contents are don't-care.
- Hit: hitN = validN && tagN==tag. Both ways hitting is impossible by construction; if it occurs, way0 wins.
- No request (MEM_R_EN=0, MEM_W_EN=0): ready=1, no state change.
- MEM_R_EN and MEM_W_EN both high is illegal; the block services the read and ignores the write.
- FSM states: IDLE, RD_MISS, WR_THRU.
- IDLE + read hit:
  - rdata = hit way data, combinationally; ready=1 the same cycle (zero-stall).
  - At the clock edge, lru = the other way (lru <= hit0 ? 1 : 0).
- IDLE + read miss:
  - ready=0; go to RD_MISS next edge.
  - mem_rd_en is asserted combinationally in IDLE on a miss and held in RD_MISS.
- RD_MISS:
  - Hold mem_rd_en=1 until mem_ready=1.
  - On mem_ready: rdata = mem_rdata, ready=1 that cycle.
  - Victim is the first invalid way (way0 preferred), else way selected by lru. Write tag, data and valid=1 into the victim; set lru to the non-victim way; return to IDLE.
- IDLE + write:
  - mem_wr_en=1, ready=0; go to WR_THRU.
- WR_THRU:
  - Hold mem_wr_en until mem_ready; ready=1 in the mem_ready cycle; return to IDLE.
  - On a hit (evaluated in that cycle), update the hit way data with wdata and set lru to the non-hit way.
  - On a miss, do not allocate.
- The requester holds address, wdata and the enables stable while ready=0. Changes during a stall are undefined.
- A mem_ready in IDLE with no outstanding request is ignored.
- Reset mid-miss or mid-write: the request is abandoned, enables drop immediately and no fill occurs. The backing controller is reset by the same rst.
- Sequential request latency:
  - read hit: 0 stall cycles
  - read miss: 1 + memory latency
  - write: 1 + memory latency

Optional Feature:
CACHE_STATS_EN: when defined, adds outputs hit_count and miss_count (each 32 bits, saturating, cleared by rst). They increment once per completed read, on the ready=1 cycle: hit_count for IDLE hits, miss_count for RD_MISS fills. Writes are not counted. When undefined, the ports and logic are absent and the behaviour is otherwise identical.

Decomposition:
- Package cache_pkg holds:
  - FSM state enum (IDLE, RD_MISS, WR_THRU)
  - way-select typedef
  - localparams SETS=2**INDEX_W and OFFSET_W=2
- Sub-module cache_set_array holds the valid/tag/data/lru storage:
  - async-reset valid/lru vectors, plain tag/data arrays
  - one read port by index
  - one write port with way select and field enables
- The FSM, hit logic and handshake remain in assoc_cache_ctrl.

Test Plan:
- Reset, then read 0x0000_0400 with memory returning 0xDEAD_BEEF after 3 cycles -> mem_rd_en high 4 cycles, ready low 4 cycles, rdata=0xDEAD_BEEF on the mem_ready cycle; immediate re-read hits with ready=1 and no mem_rd_en.
- Read misses at 0x0400 and 0x1400 (same index 0, different tags) -> fill way0 then way1; read 0x0400 again (lru -> way1); miss 0x2400 -> evicts way1 (0x1400); 0x0400 still hits.
- Write 0x0000_1234 to cached 0x0400 -> mem_wr_en until mem_ready, ready only on the mem_ready cycle; subsequent read hit returns 0x0000_1234.
- Write to uncached 0x3800 -> backing write issued, no allocation; next read of 0x3800 misses.
- Assert rst during RD_MISS before mem_ready -> mem_rd_en=0 immediately, ready=1; prior-hit line 0x0400 now misses (valid cleared).
- With CACHE_STATS_EN: 2 misses and 3 hits -> miss_count=2, hit_count=3; a write leaves both unchanged.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the 2-way set-associative cache.
package cache_pkg;

    localparam int OFFSET_W    = 2;
    localparam int DEF_INDEX_W = 6;
    localparam int SETS        = 2 ** DEF_INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        RD_MISS,
        WR_THRU
    } state_e;

    typedef enum logic {
        WAY0 = 1'b0,
        WAY1 = 1'b1
    } way_e;

endpackage

// File: rtl/assoc_cache_ctrl_if.sv
// Pipeline-side and backing-memory-side bus of the cache controller.
interface assoc_cache_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic              MEM_R_EN;
    logic              MEM_W_EN;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  address, wdata, MEM_R_EN, MEM_W_EN,
        input  mem_rdata, mem_ready,
        output rdata, ready,
        output mem_rd_en, mem_wr_en, mem_addr, mem_wdata
    );

    modport master (
        output address, wdata, MEM_R_EN, MEM_W_EN,
        output mem_rdata, mem_ready,
        input  rdata, ready,
        input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_set_array.sv
// Valid/tag/data/LRU storage for two ways; valid and LRU reset, tag/data do not.
module cache_set_array
    import cache_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 10,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_idx_i,
    output logic               valid0_o,
    output logic               valid1_o,
    output logic [TAG_W-1:0]   tag0_o,
    output logic [TAG_W-1:0]   tag1_o,
    output logic [DATA_W-1:0]  data0_o,
    output logic [DATA_W-1:0]  data1_o,
    output way_e               lru_o,
    input  logic [INDEX_W-1:0] wr_idx_i,
    input  way_e               wr_way_i,
    input  logic               valid_we_i,
    input  logic               tag_we_i,
    input  logic               data_we_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [DATA_W-1:0]  wr_data_i,
    input  logic               lru_we_i,
    input  way_e               lru_i
);
    localparam int NSETS = 1 << INDEX_W;

    logic [NSETS-1:0]  valid0_q;
    logic [NSETS-1:0]  valid1_q;
    logic [NSETS-1:0]  lru_q;
    logic [TAG_W-1:0]  tag0_q  [NSETS];
    logic [TAG_W-1:0]  tag1_q  [NSETS];
    logic [DATA_W-1:0] data0_q [NSETS];
    logic [DATA_W-1:0] data1_q [NSETS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid0_q <= '0;
            valid1_q <= '0;
            lru_q    <= '0;
        end else begin
            if (valid_we_i && wr_way_i == WAY0) valid0_q[wr_idx_i] <= 1'b1;
            if (valid_we_i && wr_way_i == WAY1) valid1_q[wr_idx_i] <= 1'b1;
            if (lru_we_i) lru_q[wr_idx_i] <= lru_i;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we_i && wr_way_i == WAY0) tag0_q[wr_idx_i] <= wr_tag_i;
        if (tag_we_i && wr_way_i == WAY1) tag1_q[wr_idx_i] <= wr_tag_i;
        if (data_we_i && wr_way_i == WAY0) data0_q[wr_idx_i] <= wr_data_i;
        if (data_we_i && wr_way_i == WAY1) data1_q[wr_idx_i] <= wr_data_i;
    end

    assign valid0_o = valid0_q[rd_idx_i];
    assign valid1_o = valid1_q[rd_idx_i];
    assign tag0_o   = tag0_q[rd_idx_i];
    assign tag1_o   = tag1_q[rd_idx_i];
    assign data0_o  = data0_q[rd_idx_i];
    assign data1_o  = data1_q[rd_idx_i];
    assign lru_o    = way_e'(lru_q[rd_idx_i]);

endmodule

// File: rtl/assoc_cache_ctrl.sv
// 2-way write-through, no-write-allocate cache controller with per-set LRU.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module assoc_cache_ctrl
    import cache_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int INDEX_W = $clog2(SETS),
    parameter int TAG_W   = 10,
    parameter int ADDR_W  = 32
) (
    input  logic clk,
    input  logic rst,
`ifdef CACHE_STATS_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    assoc_cache_ctrl_if.slave bus_if
);
    localparam int TAG_LO = INDEX_W + OFFSET_W;

    state_e              state_q, state_d;
    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    tag;
    logic                v0, v1;
    logic [TAG_W-1:0]    t0, t1;
    logic [DATA_W-1:0]   d0, d1;
    way_e                lru;
    logic                hit0, hit1, hit;
    way_e                hit_way, victim;
    logic [DATA_W-1:0]   hit_data;

    logic                ready_c, rd_en_c, wr_en_c;
    logic [DATA_W-1:0]   rdata_c, wr_data_c;
    logic                fill_c, data_we_c, lru_we_c;
    way_e                wr_way_c, lru_c;

    assign idx = bus_if.address[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign tag = bus_if.address[TAG_W+TAG_LO-1:TAG_LO];

    cache_set_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (idx),
        .valid0_o   (v0),
        .valid1_o   (v1),
        .tag0_o     (t0),
        .tag1_o     (t1),
        .data0_o    (d0),
        .data1_o    (d1),
        .lru_o      (lru),
        .wr_idx_i   (idx),
        .wr_way_i   (wr_way_c),
        .valid_we_i (fill_c),
        .tag_we_i   (fill_c),
        .data_we_i  (data_we_c),
        .wr_tag_i   (tag),
        .wr_data_i  (wr_data_c),
        .lru_we_i   (lru_we_c),
        .lru_i      (lru_c)
    );

    // way0 wins if both ways ever match
    assign hit0     = v0 && (t0 == tag);
    assign hit1     = v1 && (t1 == tag) && !hit0;
    assign hit      = hit0 || hit1;
    assign hit_way  = hit0 ? WAY0 : WAY1;
    assign hit_data = hit0 ? d0 : d1;
    assign victim   = !v0 ? WAY0 : (!v1 ? WAY1 : lru);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        ready_c   = 1'b1;
        rdata_c   = '0;
        rd_en_c   = 1'b0;
        wr_en_c   = 1'b0;
        fill_c    = 1'b0;
        data_we_c = 1'b0;
        wr_way_c  = WAY0;
        wr_data_c = bus_if.mem_rdata;
        lru_we_c  = 1'b0;
        lru_c     = WAY0;
        // outputs are forced idle while reset is held
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (bus_if.MEM_R_EN) begin
                        if (hit) begin
                            rdata_c  = hit_data;
                            lru_we_c = 1'b1;
                            lru_c    = way_e'(~hit_way);
                        end else begin
                            rd_en_c = 1'b1;
                            ready_c = 1'b0;
                            state_d = RD_MISS;
                        end
                    end else if (bus_if.MEM_W_EN) begin
                        wr_en_c = 1'b1;
                        ready_c = 1'b0;
                        state_d = WR_THRU;
                    end
                end
                RD_MISS: begin
                    if (bus_if.mem_ready) begin
                        rdata_c  = bus_if.mem_rdata;
                        fill_c   = 1'b1;
                        data_we_c = 1'b1;
                        wr_way_c = victim;
                        lru_we_c = 1'b1;
                        lru_c    = way_e'(~victim);
                        state_d  = IDLE;
                    end else begin
                        rd_en_c = 1'b1;
                        ready_c = 1'b0;
                    end
                end
                WR_THRU: begin
                    if (bus_if.mem_ready) begin
                        if (hit) begin
                            data_we_c = 1'b1;
                            wr_way_c  = hit_way;
                            wr_data_c = bus_if.wdata;
                            lru_we_c  = 1'b1;
                            lru_c     = way_e'(~hit_way);
                        end
                        state_d = IDLE;
                    end else begin
                        wr_en_c = 1'b1;
                        ready_c = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus_if.ready     = ready_c;
    assign bus_if.rdata     = rdata_c;
    assign bus_if.mem_rd_en = rd_en_c;
    assign bus_if.mem_wr_en = wr_en_c;
    assign bus_if.mem_addr  = bus_if.address;
    assign bus_if.mem_wdata = bus_if.wdata;

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        hit_evt, miss_evt;

    assign hit_evt  = (state_q == IDLE) && bus_if.MEM_R_EN && hit;
    assign miss_evt = (state_q == RD_MISS) && bus_if.mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_evt && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_evt && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Self-checking bench: directed vector table, corner sequences, random vs LRU-list model.
module tb_assoc_cache_ctrl;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 6;
    localparam int TW = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    assoc_cache_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    assoc_cache_ctrl #(
        .DATA_W  (DW),
        .INDEX_W (IW),
        .TAG_W   (TW),
        .ADDR_W  (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef CACHE_STATS_EN
        .hit_count  (hit_count),
        .miss_count (miss_count),
`endif
        .bus_if     (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // backing memory contents
    logic [31:0] bmem [logic [31:0]];

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // reference: per set, a recency list of at most two lines (front = LRU)
    typedef struct {
        logic [TW-1:0] tag;
        logic [31:0]   data;
    } line_t;
    line_t mset [1<<IW][$];

    function automatic void model_clear();
        for (int i = 0; i < (1 << IW); i++) mset[i].delete();
    endfunction

    function automatic void model_access(input logic [31:0] a, input bit wr,
                                         input logic [31:0] wd,
                                         output bit hit, output logic [31:0] d);
        int s;
        logic [TW-1:0] t;
        line_t l;
        int pos;
        s = int'(a[IW+1:2]);
        t = a[TW+IW+1:IW+2];
        hit = 1'b0;
        d = '0;
        pos = -1;
        for (int i = 0; i < mset[s].size(); i++)
            if (mset[s][i].tag == t) pos = i;
        if (pos >= 0) begin
            hit = 1'b1;
            l = mset[s][pos];
            mset[s].delete(pos);
            if (wr) l.data = wd;
            d = l.data;
            mset[s].push_back(l);
        end else if (!wr) begin
            d = mem_val(a);
            if (mset[s].size() == 2) void'(mset[s].pop_front());
            l.tag = t;
            l.data = d;
            mset[s].push_back(l);
        end
    endfunction

    // one request; memory answers after (lat+1) cycles of enable
    task automatic txn(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input int lat,
                       output int stall, output logic [31:0] d,
                       output int rdc, output int wrc);
        int cnt;
        bit done;
        bit bad;
        cnt = 0; done = 1'b0; bad = 1'b0;
        stall = 0; rdc = 0; wrc = 0; d = '0;
        bus.address  = a;
        bus.wdata    = wd;
        bus.MEM_R_EN = rd;
        bus.MEM_W_EN = wr;
        for (int c = 0; c < 64 && !done; c++) begin
            bus.mem_ready = (cnt == lat + 1);
            bus.mem_rdata = bus.mem_ready ? mem_val(a) : $urandom;
            @(negedge clk);
            if (bus.mem_rd_en) rdc++;
            if (bus.mem_wr_en) wrc++;
            if (bus.mem_rd_en || bus.mem_wr_en) begin
                cnt++;
                if (bus.mem_addr !== a || bus.mem_wdata !== wd) bad = 1'b1;
            end
            if (bus.ready) begin
                done = 1'b1;
                d = bus.rdata;
                if (bus.mem_ready && wr && !rd) bmem[a] = wd;
            end else begin
                stall++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("txn_timeout", 32'd0, 32'd1);
        chk("mem_addr_wdata", {31'd0, bad}, 32'd0);
        bus.MEM_R_EN  = 1'b0;
        bus.MEM_W_EN  = 1'b0;
        bus.mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        bus.MEM_R_EN  = 1'b0;
        bus.MEM_W_EN  = 1'b0;
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        int          lat;
        int          stall;
        logic [31:0] rdata;
        int          rdc;
        int          wrc;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall, rdc, wrc, expst;
        logic [31:0] d, a, wd;
        bit hit, rd, wr;
        int exp_hits, exp_misses;

        tbl[0]  = '{0, 32'h0400, 32'h0, 3, 4, 32'hDEAD_BEEF, 4, 0};
        tbl[1]  = '{0, 32'h0400, 32'h0, 0, 0, 32'hDEAD_BEEF, 0, 0};
        tbl[2]  = '{0, 32'h1400, 32'h0, 2, 3, 32'h1111_1111, 3, 0};
        tbl[3]  = '{0, 32'h0400, 32'h0, 0, 0, 32'hDEAD_BEEF, 0, 0};
        tbl[4]  = '{0, 32'h2400, 32'h0, 1, 2, 32'h2222_2222, 2, 0};
        tbl[5]  = '{0, 32'h0400, 32'h0, 0, 0, 32'hDEAD_BEEF, 0, 0};
        tbl[6]  = '{0, 32'h1400, 32'h0, 1, 2, 32'h1111_1111, 2, 0};
        tbl[7]  = '{1, 32'h0400, 32'h1234, 2, 3, 32'h0, 0, 3};
        tbl[8]  = '{0, 32'h0400, 32'h0, 0, 0, 32'h0000_1234, 0, 0};
        tbl[9]  = '{1, 32'h3800, 32'h5678, 1, 2, 32'h0, 0, 2};
        tbl[10] = '{0, 32'h3800, 32'h0, 1, 2, 32'h0000_5678, 2, 0};
        tbl[11] = '{0, 32'h1400, 32'h0, 0, 1, 32'h1111_1111, 1, 0};

        bmem[32'h0400] = 32'hDEAD_BEEF;
        bmem[32'h1400] = 32'h1111_1111;
        bmem[32'h2400] = 32'h2222_2222;

        bus.address   = '0;
        bus.wdata     = '0;
        bus.MEM_R_EN  = 1'b0;
        bus.MEM_W_EN  = 1'b0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.ready}, 32'd1);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
        chk("rst_wr_en", {31'd0, bus.mem_wr_en}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            txn(!tbl[i].wr, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].lat,
                stall, d, rdc, wrc);
            chk($sformatf("vec%0d_stall", i), stall, tbl[i].stall);
            chk($sformatf("vec%0d_rd_cycles", i), rdc, tbl[i].rdc);
            chk($sformatf("vec%0d_wr_cycles", i), wrc, tbl[i].wrc);
            if (!tbl[i].wr) chk($sformatf("vec%0d_rdata", i), d, tbl[i].rdata);
        end
`ifdef CACHE_STATS_EN
        chk("tbl_hit_count", hit_count, 32'd4);
        chk("tbl_miss_count", miss_count, 32'd6);
`endif

        // stray mem_ready with no request must be ignored
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("idle_pulse_ready", {31'd0, bus.ready}, 32'd1);
        chk("idle_pulse_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        txn(1, 0, 32'h3800, 32'h0, 0, stall, d, rdc, wrc);
        chk("after_pulse_stall", stall, 0);
        chk("after_pulse_rdata", d, 32'h0000_5678);

        // reset in the middle of a read miss
        bus.address  = 32'h7400;
        bus.MEM_R_EN = 1'b1;
        @(negedge clk);
        chk("midrst_idle_rd_en", {31'd0, bus.mem_rd_en}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_miss_ready", {31'd0, bus.ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
        chk("midrst_ready", {31'd0, bus.ready}, 32'd1);
        bus.MEM_R_EN = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        txn(1, 0, 32'h3800, 32'h0, 0, stall, d, rdc, wrc);
        chk("postrst_miss_stall", stall, 1);
        chk("postrst_rdata", d, 32'h0000_5678);

        // randomized traffic against the recency-list model
        do_reset();
        model_clear();
        exp_hits = 0;
        exp_misses = 0;
        for (int n = 0; n < 400; n++) begin
            rd = ($urandom_range(0, 9) < 7);
            wr = !rd || ($urandom_range(0, 19) == 0);
            a  = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 3)) << 2);
            wd = $urandom;
            expst = $urandom_range(0, 3);
            model_access(a, !rd, wd, hit, d);
            if (rd) begin
                if (hit) exp_hits++;
                else     exp_misses++;
            end
            begin
                logic [31:0] got;
                int lat;
                lat = expst;
                expst = (rd && hit) ? 0 : lat + 1;
                txn(rd, wr, a, wd, lat, stall, got, rdc, wrc);
                chk("rnd_stall", stall, expst);
                if (rd) begin
                    chk("rnd_rdata", got, d);
                    chk("rnd_rd_cycles", rdc, expst);
                    chk("rnd_wr_cycles", wrc, 0);
                end else begin
                    chk("rnd_wr_cycles", wrc, expst);
                end
            end
            if ($urandom_range(0, 7) == 0) begin
                bus.mem_ready = 1'b1;
                @(posedge clk);
                #1;
                bus.mem_ready = 1'b0;
            end
        end
`ifdef CACHE_STATS_EN
        chk("rnd_hit_count", hit_count, exp_hits);
        chk("rnd_miss_count", miss_count, exp_misses);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
